instruction_sequencer: RTL and testbench

//  Multi-cycle control FSM for the single-issue RV32I core. Fetches from instruction memory

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/opcode_decoder.sv | 41 ++++
 rtl/instruction_sequencer.sv | 153 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: base opcodes,
// immediate-type select encoding, sequencer states and the NOP word.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_SB   = 3'd2,
    IMM_U    = 3'd3,
    IMM_UJ   = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } seq_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational RV32I base-opcode classifier: immediate type, instruction
// class flags, register write-back and legality.
module opcode_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       writes_rd,
  output logic       legal
);

  // Classify the opcode; anything outside the base set is flagged illegal
  always_comb begin
    imm_sel   = IMM_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    writes_rd = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin imm_sel = IMM_I;  writes_rd = 1'b1; end
      OPC_LOAD:   begin imm_sel = IMM_I;  writes_rd = 1'b1; is_load = 1'b1; end
      OPC_JALR:   begin imm_sel = IMM_I;  writes_rd = 1'b1; is_jalr = 1'b1; end
      OPC_STORE:  begin imm_sel = IMM_S;  is_store = 1'b1; end
      OPC_BRANCH: begin imm_sel = IMM_SB; is_branch = 1'b1; end
      OPC_LUI:    begin imm_sel = IMM_U;  writes_rd = 1'b1; end
      OPC_AUIPC:  begin imm_sel = IMM_U;  writes_rd = 1'b1; end
      OPC_JAL:    begin imm_sel = IMM_UJ; writes_rd = 1'b1; is_jal = 1'b1; end
      OPC_OP:     begin writes_rd = 1'b1; end
      default:    begin legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core:
// FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH.
// Optional feature macro ILLEGAL_TRAP_EN: an unrecognised opcode parks the
// sequencer in TRAP with a sticky illegal_instr flag; without it such an
// opcode retires as a NOP.
module instruction_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] program_counter,
  output logic [2:0]  imm_sel,
  input  logic [31:0] sb_target,
  input  logic [31:0] uj_target,
  input  logic [31:0] jalr_target,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_write_en,
  output logic        illegal_instr
);

  seq_state_e  state, state_nxt;
  logic [31:0] pc_q, pc_nxt, instr_q;
  logic [2:0]  imm_sel_q;
  logic        fetch_drop, fetch_done;

  logic [2:0]  dec_imm_sel;
  logic        dec_load, dec_store, dec_branch, dec_jal, dec_jalr;
  logic        dec_writes_rd, dec_legal;
  logic        unused_ok;

  opcode_decoder u_dec (
    .opcode    (instr_q[6:0]),
    .imm_sel   (dec_imm_sel),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_branch (dec_branch),
    .is_jal    (dec_jal),
    .is_jalr   (dec_jalr),
    .writes_rd (dec_writes_rd),
    .legal     (dec_legal)
  );

  // JALR clears bit 0 of its target, so that bit is never consumed
  assign unused_ok = ^{dec_legal, jalr_target[0]};

  generate
    if (FETCH_TIMEOUT > 0) begin : g_tmo
      logic [31:0] tmo_cnt;
      // Count unanswered fetch cycles; cleared outside FETCH and after a dropped cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          tmo_cnt <= '0;
        end else if (state != ST_FETCH || fetch_drop) begin
          tmo_cnt <= '0;
        end else if (!imem_ack) begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end
      assign fetch_drop = (state == ST_FETCH) && (tmo_cnt == 32'(FETCH_TIMEOUT));
    end else begin : g_no_tmo
      assign fetch_drop = 1'b0;
    end
  endgenerate

  assign imem_req        = !rst && (state == ST_FETCH) && !fetch_drop;
  assign fetch_done      = imem_req && imem_ack;
  assign imem_addr       = pc_q;
  assign program_counter = pc_q;
  assign instruction     = instr_q;
  assign imm_sel         = imm_sel_q;
  assign dmem_req        = !rst && (state == ST_MEM);
  assign dmem_we         = dmem_req && dec_store;
  assign reg_write_en    = !rst && (state == ST_WB) && dec_writes_rd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (fetch_done) state_nxt = ST_DECODE;
`ifdef ILLEGAL_TRAP_EN
      ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_TRAP;
`else
      ST_DECODE: state_nxt = ST_EXEC;
`endif
      ST_EXEC:   state_nxt = (dec_load || dec_store) ? ST_MEM : ST_WB;
      ST_MEM:    if (dmem_ack) state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // Next PC chosen at write-back; sequential PC wraps naturally at 2^32
  always_comb begin
    pc_nxt = pc_q + 32'd4;
    if (dec_branch && branch_taken) begin
      pc_nxt = sb_target;
    end else if (dec_jal) begin
      pc_nxt = uj_target;
    end else if (dec_jalr) begin
      pc_nxt = {jalr_target[31:1], 1'b0};
    end
  end

  // Instruction register, immediate select and PC commit
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      imm_sel_q <= IMM_NONE;
    end else begin
      if (state == ST_FETCH && fetch_done) instr_q <= imem_rdata;
      if (state == ST_DECODE) imm_sel_q <= dec_imm_sel;
      if (state == ST_WB) pc_q <= pc_nxt;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == ST_DECODE && !dec_legal) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer (RESET_PC=0x100, FETCH_TIMEOUT=4).
module tb_instruction_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] instruction, program_counter;
  logic [2:0]  imm_sel;
  logic [31:0] sb_target = '0, uj_target = '0, jalr_target = '0;
  logic        branch_taken = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        reg_write_en, illegal_instr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_pc = RPC;

  instruction_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .program_counter(program_counter), .imm_sel(imm_sel),
    .sb_target(sb_target), .uj_target(uj_target), .jalr_target(jalr_target),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_write_en(reg_write_en), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural effect of one instruction, straight from the ISA rules
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                    output logic [31:0] npc, output bit wr,
                                    output logic [2:0] sel, output bit mem, output bit st);
    npc = pc + 32'd4; wr = 0; sel = 3'd7; mem = 0; st = 0;
    case (ins[6:0])
      7'h13: begin sel = 3'd0; wr = 1; end
      7'h03: begin sel = 3'd0; wr = 1; mem = 1; end
      7'h67: begin sel = 3'd0; wr = 1; npc = jalr_target & 32'hFFFF_FFFE; end
      7'h23: begin sel = 3'd1; mem = 1; st = 1; end
      7'h63: begin sel = 3'd2; if (branch_taken) npc = sb_target; end
      7'h37, 7'h17: begin sel = 3'd3; wr = 1; end
      7'h6F: begin sel = 3'd4; wr = 1; npc = uj_target; end
      7'h33: begin wr = 1; end
      default: ;
    endcase
  endfunction

  // Runs one instruction starting at a negedge in the first FETCH cycle; returns at the next FETCH
  task automatic exec_instr(input logic [31:0] ins, input int fw, input int dw, input string nm);
    logic [31:0] exp_pc; bit exp_w; logic [2:0] exp_sel; bit mem, st;
    int reqc = 0, dreq = 0, dwe = 0, wen = 0, lat = 0, cyc = 0, exp_lat;
    bit acked = 0, done = 0;
    ref_model(ins, model_pc, exp_pc, exp_w, exp_sel, mem, st);
    exp_lat = 3 + (mem ? dw : 0);
    while (!done) begin
      if (cyc > 100) begin
        n_cmp++; n_err++;
        $display("FAIL %s_timeout: no return to fetch after %0d cycles, required < 100", nm, cyc);
        imem_ack = 0; dmem_ack = 0; done = 1;
      end else if (!acked) begin
        dmem_ack = 0;
        if (imem_req) begin
          if (reqc == 0) begin
            n_cmp++;
            if (imem_addr !== model_pc) begin
              n_err++; $display("FAIL %s_addr: got %h required %h", nm, imem_addr, model_pc);
            end
          end
          if (reqc == fw) begin imem_ack = 1; imem_rdata = ins; acked = 1; end
          reqc++;
        end
      end else if (imem_req) begin
        imem_ack = 0; dmem_ack = 0; done = 1;
      end else begin
        lat++;
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        if (reg_write_en) wen++;
        if (dmem_req) begin
          dreq++;
          if (dmem_we) dwe++;
          dmem_ack = (dreq == dw);
        end else begin
          dmem_ack = 1'($urandom_range(0, 1));
        end
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL %s_pc: got %h required %h", nm, imem_addr, exp_pc); end
    n_cmp++; if (instruction !== ins) begin n_err++; $display("FAIL %s_ir: got %h required %h", nm, instruction, ins); end
    n_cmp++; if (imm_sel !== exp_sel) begin n_err++; $display("FAIL %s_immsel: got %0d required %0d", nm, imm_sel, exp_sel); end
    n_cmp++; if (wen !== (exp_w ? 1 : 0)) begin n_err++; $display("FAIL %s_wen: got %0d cycles required %0d", nm, wen, exp_w); end
    n_cmp++; if (dreq !== (mem ? dw : 0)) begin n_err++; $display("FAIL %s_dreq: got %0d cycles required %0d", nm, dreq, mem ? dw : 0); end
    n_cmp++; if (dwe !== (st ? dw : 0)) begin n_err++; $display("FAIL %s_dwe: got %0d cycles required %0d", nm, dwe, st ? dw : 0); end
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d required %0d", nm, lat, exp_lat); end
    n_cmp++; if (illegal_instr !== 1'b0) begin n_err++; $display("FAIL %s_illegal: got %b required 0", nm, illegal_instr); end
    model_pc = exp_pc;
  endtask

  task automatic test_reset();
    rst = 1; imem_ack = 0; dmem_ack = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_imem_req: got %b required 0", imem_req); end
    n_cmp++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_err++; $display("FAIL rst_dmem: got %b%b required 00", dmem_req, dmem_we); end
    n_cmp++; if (reg_write_en !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b required 0", reg_write_en); end
    n_cmp++; if (program_counter !== RPC) begin n_err++; $display("FAIL rst_pc: got %h required %h", program_counter, RPC); end
    n_cmp++; if (instruction !== 32'h0000_0013) begin n_err++; $display("FAIL rst_ir: got %h required 00000013", instruction); end
    n_cmp++; if (imm_sel !== 3'd7) begin n_err++; $display("FAIL rst_immsel: got %0d required 7", imm_sel); end
    n_cmp++; if (illegal_instr !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b required 0", illegal_instr); end
    rst = 0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rel_imem_req: got %b required 1", imem_req); end
    n_cmp++; if (imem_addr !== RPC) begin n_err++; $display("FAIL rel_addr: got %h required %h", imem_addr, RPC); end
    model_pc = RPC;
  endtask

  task automatic test_addi();
    exec_instr(32'h0050_0093, 3, 0, "addi");
  endtask

  task automatic test_branch();
    sb_target = 32'h80; branch_taken = 1;
    exec_instr(32'h0000_0063, 1, 0, "beq_taken");
    branch_taken = 0;
    exec_instr(32'h0000_0063, 0, 0, "beq_not");
  endtask

  task automatic test_store();
    exec_instr(32'h0011_2023, 2, 5, "sw");
  endtask

  task automatic test_jalr_wrap();
    jalr_target = 32'h203;
    exec_instr(32'h0001_00E7, 0, 0, "jalr");
    jalr_target = 32'hFFFF_FFFC;
    exec_instr(32'h0001_00E7, 1, 0, "jalr_top");
    exec_instr(32'h0050_0093, 0, 0, "addi_wrap");
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    imem_ack = 1; imem_rdata = 32'h0000_007F;
    @(negedge clk); imem_ack = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (illegal_instr !== 1'b1) begin n_err++; $display("FAIL trap_flag: got %b required 1", illegal_instr); end
      n_cmp++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || reg_write_en !== 1'b0) begin
        n_err++; $display("FAIL trap_strobes: got %b%b%b required 000", imem_req, dmem_req, reg_write_en);
      end
      n_cmp++; if (program_counter !== model_pc) begin n_err++; $display("FAIL trap_pc: got %h required %h", program_counter, model_pc); end
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_ack = 0;
    test_reset();
`else
    exec_instr(32'h0000_007F, 1, 0, "illegal_nop");
`endif
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (imem_req !== ((i % 5) != 4) || imem_addr !== model_pc) begin
        n_err++; $display("FAIL timeout_c%0d: got req=%b addr=%h required req=%b addr=%h",
                          i + 1, imem_req, imem_addr, (i % 5) != 4, model_pc);
      end
      @(negedge clk);
    end
    exec_instr(32'h0000_0033, 0, 0, "after_timeout");
  endtask

  task automatic test_abort();
    int k = 0;
    imem_ack = 1; imem_rdata = 32'h0011_2023;
    @(negedge clk); imem_ack = 0;
    while (!dmem_req && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL abort_mem: got dmem_req=%b required 1", dmem_req); end
    rst = 1;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL abort_strobes: got %b%b required 00", dmem_req, imem_req);
    end
    test_reset();
  endtask

  task automatic test_random();
    logic [6:0] opcs [11];
    logic [31:0] r;
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h33, 7'h63};
`ifndef ILLEGAL_TRAP_EN
    opcs[9] = 7'h7F;
`endif
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      sb_target = $urandom; uj_target = $urandom; jalr_target = $urandom;
      branch_taken = 1'($urandom_range(0, 1));
      exec_instr({r[31:7], opcs[$urandom_range(0, 10)]}, $urandom_range(0, 3),
                 $urandom_range(1, 4), "random");
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_store();
    test_jalr_wrap();
    test_timeout();
    test_random();
    test_abort();
    test_illegal();
    test_addi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
